// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory controller between the RV32I MEM stage and an
// on-chip word-wide RAM. Handles byte/half/word loads and stores in
// little-endian order, a memory-mapped LED register, and error detection.
// Every access stalls the core for two cycles (IDLE -> FETCH -> READ/WRITE).
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   addr        byte address of the access
//   write_data  store data, right-aligned
//   memwrite    store request
//   memread     load request
//   sign_mask   [2:0] size (001 byte, 011 half, 111 word), [3] sign-extend
//   read_data   load result
//   clk_stall   high while an access is in flight
//   led         low LED_WIDTH bits of the LED register
//   access_err  one-cycle pulse flagging a bad access
module data_mem_ctrl #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
  parameter int          LED_WIDTH   = 8,
  parameter string       INIT_FILE   = "verilog/data.hex"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           sign_mask,
  output logic [31:0]          read_data,
  output logic                 clk_stall,
  output logic [LED_WIDTH-1:0] led,
  output logic                 access_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, FETCH, READ, WRITE} state_t;

  state_t      state;
  logic [31:0] addr_buf;
  logic [31:0] wdata_buf;
  logic [3:0]  mask_buf;
  logic        rd_buf;
  logic        wr_buf;
  logic [31:0] word_buf;
  logic [31:0] led_reg;
  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             is_led;
  logic             size_ok;
  logic             misalign;
  logic             range_err;
  logic             acc_err;

  // Extract the addressed byte/half from a word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [3:0]  mask);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (mask[2:0])
      3'b001:  load_extract = {{24{mask[3] & b[7]}}, b};
      3'b011:  load_extract = {{16{mask[3] & h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  // Replace only the addressed lanes of a word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] d,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  size);
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    case (size)
      3'b001: begin
        lane_mask = 32'h0000_00FF << {lane, 3'b000};
        lane_data = {4{d[7:0]}};
      end
      3'b011: begin
        lane_mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        lane_data = {2{d[15:0]}};
      end
      default: begin
        lane_mask = '1;
        lane_data = d;
      end
    endcase
    store_merge = (w & ~lane_mask) | (lane_data & lane_mask);
  endfunction

  // Address decode on the latched request. The full 32-bit offset is
  // range-checked before its index bits are trusted; an out-of-range
  // index may still be read in FETCH but is never written or returned.
  always_comb begin
    off      = addr_buf - BASE_ADDR;
    idx      = off[IDX_W+1:2];
    is_led   = (addr_buf == LED_ADDR);
    size_ok  = (mask_buf[2:0] == 3'b001) || (mask_buf[2:0] == 3'b011) ||
               (mask_buf[2:0] == 3'b111);
    misalign = ((mask_buf[2:0] == 3'b011) && addr_buf[0]) ||
               ((mask_buf[2:0] == 3'b111) && (addr_buf[1:0] != 2'b00));
    if (is_led) range_err = (mask_buf[2:0] != 3'b111);
    else        range_err = (addr_buf < BASE_ADDR) || ((off >> (IDX_W + 2)) != 32'd0);
    acc_err  = !size_ok || misalign || range_err;
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clk_stall  <= 1'b0;
      read_data  <= 32'd0;
      led_reg    <= 32'd0;
      access_err <= 1'b0;
    end else begin
      access_err <= 1'b0;
      case (state)
        // Request capture
        IDLE: begin
          if (memread || memwrite) begin
            clk_stall <= 1'b1;
            state     <= FETCH;
          end
        end
        // RAM word read into word_buf
        FETCH: state <= rd_buf ? READ : WRITE;
        // Load completion; a simultaneous write flag is reported as an error
        READ: begin
          read_data  <= acc_err ? 32'd0
                                : load_extract(is_led ? led_reg : word_buf, off[1:0], mask_buf);
          access_err <= acc_err || wr_buf;
          clk_stall  <= 1'b0;
          state      <= IDLE;
        end
        // Store completion
        WRITE: begin
          if (!acc_err && is_led) led_reg <= wdata_buf;
          access_err <= acc_err;
          clk_stall  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request buffers and RAM read port; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && (memread || memwrite)) begin
      addr_buf  <= addr;
      wdata_buf <= write_data;
      mask_buf  <= sign_mask;
      rd_buf    <= memread;
      wr_buf    <= memwrite;
    end
    if (state == FETCH) word_buf <= ram[idx];
  end

  // RAM write port; an access abandoned by reset never reaches WRITE.
  always_ff @(posedge clk) begin
    if (state == WRITE && !acc_err && !is_led && !reset)
      ram[idx] <= store_merge(word_buf, wdata_buf, off[1:0], mask_buf[2:0]);
  end

  assign led = led_reg[LED_WIDTH-1:0];

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int          DEPTH = 512;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LEDA  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic [7:0]  led;
  logic        access_err;

  int checks = 0;
  int errors = 0;

  // Reference state: byte-addressed memory, LED register, last load result.
  logic [7:0]  mem_m [bit [31:0]];
  logic [31:0] led_m = 32'd0;
  logic [31:0] rd_m  = 32'd0;

  data_mem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .LED_ADDR   (LEDA),
    .LED_WIDTH  (8),
    .INIT_FILE  ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .write_data(write_data),
    .memwrite  (memwrite),
    .memread   (memread),
    .sign_mask (sign_mask),
    .read_data (read_data),
    .clk_stall (clk_stall),
    .led       (led),
    .access_err(access_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one access, from the byte-level rules.
  function automatic void model(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] sm,
                                output logic exp_err);
    int          n;
    bit          bad;
    logic [31:0] v;
    case (sm[2:0])
      3'b001:  n = 1;
      3'b011:  n = 2;
      3'b111:  n = 4;
      default: n = 0;
    endcase
    bad = (n == 0);
    if (!bad && (a % n) != 0) bad = 1;
    if (a == LEDA) begin
      if (n != 4) bad = 1;
    end else if (a < BASE || ((a - BASE) / 4) >= DEPTH) begin
      bad = 1;
    end
    exp_err = bad || (rd && wr);
    if (rd) begin
      if (bad) rd_m = 32'd0;
      else if (a == LEDA) rd_m = led_m;
      else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | ({24'd0, mem_m[a + i]} << (8 * i));
        if (sm[3] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd_m = v;
      end
    end else if (wr && !bad) begin
      if (a == LEDA) led_m = d;
      else for (int i = 0; i < n; i++) mem_m[a + i] = 8'(d >> (8 * i));
    end
  endfunction

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] sm, input string tag);
    logic e;
    int   n;
    model(rd, wr, a, d, sm, e);
    @(negedge clk);
    memread = rd; memwrite = wr; addr = a; write_data = d; sign_mask = sm;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    n = 0;
    while (clk_stall && n < 8) begin
      n++;
      @(posedge clk); #1;
    end
    check32({tag, "_stall"}, n, 32'd2);
    check32({tag, "_err"}, {31'd0, access_err}, {31'd0, e});
    check32({tag, "_rdata"}, read_data, rd_m);
    check32({tag, "_led"}, {24'd0, led}, {24'd0, led_m[7:0]});
  endtask

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0;
    addr = 32'd0; write_data = 32'd0; sign_mask = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_stall", {31'd0, clk_stall}, 32'd0);
    check32("rst_rdata", read_data, 32'd0);
    check32("rst_led", {24'd0, led}, 32'd0);
    check32("rst_err", {31'd0, access_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Known contents for the first 16 words.
    for (int w = 0; w < 16; w++) access(0, 1, BASE + 4 * w, $urandom, 4'b0111, "init");

    access(0, 1, 32'h1004, 32'hDEAD_BEEF, 4'b0111, "w_store");
    access(1, 0, 32'h1004, 32'd0, 4'b0111, "w_load");
    check32("plan_word", read_data, 32'hDEAD_BEEF);

    access(0, 1, 32'h1004, 32'h1122_3344, 4'b0111, "w_store2");
    access(0, 1, 32'h1005, 32'h0000_0080, 4'b0001, "b_store");
    access(1, 0, 32'h1005, 32'd0, 4'b1001, "b_load_s");
    check32("plan_byte_s", read_data, 32'hFFFF_FF80);
    access(1, 0, 32'h1005, 32'd0, 4'b0001, "b_load_u");
    check32("plan_byte_u", read_data, 32'h0000_0080);
    access(1, 0, 32'h1004, 32'd0, 4'b0111, "b_word");
    check32("plan_byte_word", read_data, 32'h1122_8044);

    access(0, 1, 32'h1008, 32'h1234_5678, 4'b0111, "h_pre");
    access(0, 1, 32'h100A, 32'h0000_ABCD, 4'b0011, "h_store");
    access(1, 0, 32'h100A, 32'd0, 4'b1011, "h_load_s");
    check32("plan_half_s", read_data, 32'hFFFF_ABCD);
    access(1, 0, 32'h1008, 32'd0, 4'b0111, "h_word");
    check32("plan_half_word", read_data, 32'hABCD_5678);

    access(0, 1, LEDA, 32'h0000_005A, 4'b0111, "led_store");
    check32("plan_led", {24'd0, led}, 32'h0000_005A);
    access(1, 0, LEDA, 32'd0, 4'b0111, "led_load");
    check32("plan_led_load", read_data, 32'h0000_005A);

    access(1, 0, 32'h1002, 32'd0, 4'b0111, "err_misalign");
    access(0, 1, BASE + 4 * DEPTH, 32'hFFFF_FFFF, 4'b0111, "err_range");
    access(1, 0, BASE, 32'd0, 4'b0111, "err_range_chk");
    access(1, 0, 32'h1004, 32'd0, 4'b0101, "err_size");
    access(1, 0, 32'h0FFC, 32'd0, 4'b0111, "err_below");
    access(1, 0, LEDA, 32'd0, 4'b0001, "err_led_byte");
    access(1, 1, 32'h1004, 32'h5555_5555, 4'b0111, "both");
    access(1, 0, 32'h1004, 32'd0, 4'b0111, "both_chk");

    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      logic [3:0]  sm;
      int          pick;
      int          op;
      a = BASE + $urandom_range(0, 63);
      pick = $urandom_range(0, 9);
      if (pick == 0) a = LEDA;
      else if (pick == 1) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0:       sm[2:0] = 3'b001;
        1:       sm[2:0] = 3'b011;
        2, 3:    sm[2:0] = 3'b111;
        default: sm[2:0] = 3'b101;
      endcase
      sm[3] = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 9);
      access(op < 5 || op == 9, op >= 5, a, $urandom, sm, "rnd");
    end

    // Reset during the FETCH cycle of a store abandons it.
    access(0, 1, LEDA, 32'h0000_00A5, 4'b0111, "led_pre_rst");
    @(negedge clk);
    memwrite = 1'b1; memread = 1'b0; addr = 32'h1010;
    write_data = 32'hCAFE_F00D; sign_mask = 4'b0111;
    @(posedge clk); #1;
    memwrite = 1'b0;
    #2 reset = 1'b1;
    #1;
    check32("midrst_stall", {31'd0, clk_stall}, 32'd0);
    check32("midrst_led", {24'd0, led}, 32'd0);
    check32("midrst_rdata", read_data, 32'd0);
    check32("midrst_err", {31'd0, access_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    led_m = 32'd0;
    rd_m  = 32'd0;
    access(1, 0, 32'h1010, 32'd0, 4'b0111, "post_rst_load");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
